// File: rtl/bram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_pkg
//  Description : Shared defaults and sizing helpers for the BRAM TX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_fifo_pkg;

    localparam int unsigned c_WIDTH_DATA_DEF = 48;
    localparam int unsigned c_WIDTH_ADDR_DEF = 8;
    localparam int unsigned c_PTR_W_DEF      = c_WIDTH_ADDR_DEF + 1;

    function automatic int unsigned fifo_depth(input int unsigned width_addr);
        return 32'd1 << width_addr;
    endfunction

    // Extra MSB is the wrap bit that tells full from empty.
    function automatic int unsigned ptr_width(input int unsigned width_addr);
        return width_addr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdp_core.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdp_core
//  Description : Registered-read simple-dual-port RAM, no reset on array/data.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_core
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = c_WIDTH_DATA_DEF,
    parameter int unsigned WIDTH_ADDR = c_WIDTH_ADDR_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [WIDTH_ADDR-1:0] i_waddr,
    input  logic [WIDTH_DATA-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [WIDTH_ADDR-1:0] i_raddr,
    output logic [WIDTH_DATA-1:0] o_rdata
);

    localparam int unsigned c_DEPTH = fifo_depth(WIDTH_ADDR);

    logic [WIDTH_DATA-1:0] r_mem [0:c_DEPTH-1];
    logic [WIDTH_DATA-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bram_fifo_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_tx
//  Description : Single-clock BRAM FIFO between DDR3 read path and UART TX.
//                Define BRAM_FIFO_FWFT_EN for first-word-fall-through output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_tx
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = c_WIDTH_DATA_DEF,
    parameter int unsigned WIDTH_ADDR = c_WIDTH_ADDR_DEF,
    parameter int unsigned AF_THRESH  = 252
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [WIDTH_DATA-1:0] i_WDATA,
    output logic                  o_full,
    output logic                  o_almost_full,
    input  logic                  i_rd_en,
    output logic [WIDTH_DATA-1:0] o_RDATA,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic [WIDTH_ADDR:0]   o_count,
    input  logic                  i_clr_err,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned          c_PTR_W = ptr_width(WIDTH_ADDR);
    localparam int unsigned          c_DEPTH = fifo_depth(WIDTH_ADDR);
    localparam logic [c_PTR_W-1:0]   c_FULL  = c_PTR_W'(c_DEPTH);
    localparam logic [c_PTR_W-1:0]   c_AF    = c_PTR_W'(AF_THRESH);

    logic [c_PTR_W-1:0]    r_wptr, r_rptr, r_count;
    logic                  r_empty, r_full, r_af, r_rd_valid, r_have_data;
    logic                  r_ovf, r_unf;
    logic [c_PTR_W-1:0]    w_wptr_nxt, w_rptr_nxt, w_count_nxt;
    logic                  w_push, w_rd_issue, w_rd_valid_nxt, w_empty_nxt;
    logic                  w_ovf_evt, w_unf_evt;
    logic [WIDTH_DATA-1:0] w_core_q;

    assign w_push     = i_wr_en && !r_full;
    assign w_ovf_evt  = i_wr_en && r_full;
    assign w_wptr_nxt = r_wptr + {{WIDTH_ADDR{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{WIDTH_ADDR{1'b0}}, w_rd_issue};

`ifdef BRAM_FIFO_FWFT_EN
    // Prefetch whenever the RAM holds a word and the output slot is free or being consumed.
    assign w_rd_issue     = (r_wptr != r_rptr) && (!r_rd_valid || i_rd_en);
    assign w_rd_valid_nxt = w_rd_issue || (r_rd_valid && !i_rd_en);
    assign w_unf_evt      = i_rd_en && !r_rd_valid;
    assign w_count_nxt    = w_wptr_nxt - w_rptr_nxt + {{WIDTH_ADDR{1'b0}}, w_rd_valid_nxt};
    assign w_empty_nxt    = !w_rd_valid_nxt;
`else
    assign w_rd_issue     = i_rd_en && !r_empty;
    assign w_rd_valid_nxt = w_rd_issue;
    assign w_unf_evt      = i_rd_en && r_empty;
    assign w_count_nxt    = w_wptr_nxt - w_rptr_nxt;
    assign w_empty_nxt    = (w_count_nxt == '0);
`endif

    bram_sdp_core #(
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH_ADDR (WIDTH_ADDR)
    ) u_core (
        .i_clk   (i_clk),
        .i_we    (w_push && i_rst_n),
        .i_waddr (r_wptr[WIDTH_ADDR-1:0]),
        .i_wdata (i_WDATA),
        .i_re    (w_rd_issue && i_rst_n),
        .i_raddr (r_rptr[WIDTH_ADDR-1:0]),
        .o_rdata (w_core_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_af        <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_have_data <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_empty    <= w_empty_nxt;
            r_full     <= (w_count_nxt == c_FULL);
            r_af       <= (w_count_nxt >= c_AF);
            r_rd_valid <= w_rd_valid_nxt;
            if (w_rd_issue) begin
                r_have_data <= 1'b1;
            end
            r_ovf <= w_ovf_evt || (r_ovf && !i_clr_err);
            r_unf <= w_unf_evt || (r_unf && !i_clr_err);
        end
    end

    // The RAM data register is unreset; mask it until a read has landed since reset.
    assign o_RDATA       = r_have_data ? w_core_q : '0;
    assign o_rd_valid    = r_rd_valid;
    assign o_empty       = r_empty;
    assign o_full        = r_full;
    assign o_almost_full = r_af;
    assign o_count       = r_count;
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_unf;

endmodule
`default_nettype wire
